// File: rtl/tcdm_burst_reader.sv
// tcdm_burst_reader: reads len_i consecutive 32-bit words from a TCDM slave
// and presents them in order on a valid/ready stream. Requests are issued
// only when the response buffer has room for their data.
module tcdm_burst_reader #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [LEN_WIDTH-1:0]    len_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    tcdm_req_o,
  output logic [ADDR_WIDTH-1:0]   tcdm_add_o,
  output logic                    tcdm_wen_o,
  output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
  output logic [DATA_WIDTH-1:0]   tcdm_wdata_o,
  input  logic                    tcdm_gnt_i,
  input  logic                    tcdm_r_valid_i,
  input  logic [DATA_WIDTH-1:0]   tcdm_r_rdata_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    valid_o,
  input  logic                    ready_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] L_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;

  state_t                 r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [LEN_WIDTH-1:0]   r_req_left, r_out_left;
  logic [CW-1:0]          r_outst, r_cnt;
  logic [PW-1:0]          r_wptr, r_rptr;
  logic [DATA_WIDTH-1:0]  r_mem [FIFO_DEPTH];
  logic                   r_req_hold, r_busy, r_done, r_armed;

  logic [CW:0]            w_sum;
  logic                   w_credit, w_req, w_grant, w_push, w_pop, w_valid;
  logic                   w_start, w_fin;
  logic                   w_unused;

  // Byte offset of the base address is dropped on purpose.
  assign w_unused = &{1'b0, base_addr_i[1:0]};

  // Credit counts both words in flight and words already buffered.
  assign w_sum    = {1'b0, r_outst} + {1'b0, r_cnt};
  assign w_credit = (w_sum < {1'b0, L_FULL});
  // A pending request is held regardless of credit; a fresh one needs credit.
  assign w_req    = r_req_hold | ((r_state == REQ) && (r_req_left != '0) && w_credit);
  assign w_grant  = w_req & tcdm_gnt_i;
  // Responses with nothing outstanding (e.g. in flight across a reset) are dropped.
  assign w_push   = tcdm_r_valid_i & (r_outst != '0);
  assign w_valid  = (r_cnt != '0);
  assign w_pop    = w_valid & ready_i;
  assign w_start  = (r_state == IDLE) && start_i;

  assign tcdm_req_o   = w_req;
  assign tcdm_add_o   = r_addr;
  assign tcdm_wen_o   = 1'b1;
  assign tcdm_be_o    = '1;
  assign tcdm_wdata_o = '0;
  assign data_o       = r_mem[r_rptr];
  assign valid_o      = w_valid;
  assign busy_o       = r_busy;
  assign done_o       = r_done;

  // Next state and the completion strobe. The last pop finishes the transfer
  // directly; DONE only raises the strobe itself when nothing was popped
  // (zero-length transfer).
  always_comb begin
    w_state_nxt = r_state;
    w_fin       = 1'b0;
    case (r_state)
      IDLE:  if (start_i) w_state_nxt = (len_i == '0) ? DONE : REQ;
      REQ:   if (w_grant && (r_req_left == LEN_WIDTH'(1))) w_state_nxt = DRAIN;
      DRAIN: if ((r_out_left == '0) || (w_pop && (r_out_left == LEN_WIDTH'(1)))) begin
               w_state_nxt = DONE;
               w_fin       = 1'b1;
             end
      DONE:  begin
               w_state_nxt = IDLE;
               w_fin       = ~r_done;
             end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control state, address and word counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_req_left <= '0;
      r_out_left <= '0;
      r_outst    <= '0;
      r_req_hold <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_req_hold <= w_req & ~tcdm_gnt_i;
      r_done     <= w_fin;
      r_armed    <= r_armed | w_start;
      if (w_start) begin
        r_addr     <= {base_addr_i[ADDR_WIDTH-1:2], 2'b00};
        r_req_left <= len_i;
        r_out_left <= len_i;
        r_busy     <= 1'b1;
      end else begin
        if (w_grant) begin
          r_addr     <= r_addr + ADDR_WIDTH'(4);
          r_req_left <= r_req_left - LEN_WIDTH'(1);
        end
        if (w_pop) r_out_left <= r_out_left - LEN_WIDTH'(1);
        if (w_fin) r_busy <= 1'b0;
      end
      case ({w_grant, w_push})
        2'b10:   r_outst <= r_outst + CW'(1);
        2'b01:   r_outst <= r_outst - CW'(1);
        default: r_outst <= r_outst;
      endcase
    end
  end

  // Response buffer: in-order FIFO, head drives the stream.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= tcdm_r_rdata_i;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Stray responses are only illegal once a transfer has been started since
  // reset; before that they are leftovers from an interrupted transfer.
  a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (tcdm_r_valid_i && r_armed) |-> (r_outst != '0));

  // Credit accounting must keep the buffer from overflowing.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_push |-> (r_cnt != L_FULL));

endmodule

// File: tb/tb_tcdm_burst_reader.sv
// Bench for tcdm_burst_reader: zero-wait slave returning rdata = address,
// queue-based model of the expected grants and stream words, directed tests.
module tb_tcdm_burst_reader;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, ready = 1'b1, stall = 1'b0, inj = 1'b0;
  logic [31:0] base = '0;
  logic [15:0] len  = '0;
  logic        busy, done, req, wen, gnt, valid;
  logic [31:0] add, wdata, data;
  logic [3:0]  be;
  logic        rv = 1'b0;
  logic [31:0] rdata = '0;

  tcdm_burst_reader #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(16), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_addr_i(base), .len_i(len),
    .busy_o(busy), .done_o(done), .tcdm_req_o(req), .tcdm_add_o(add), .tcdm_wen_o(wen),
    .tcdm_be_o(be), .tcdm_wdata_o(wdata), .tcdm_gnt_i(gnt), .tcdm_r_valid_i(rv),
    .tcdm_r_rdata_i(rdata), .data_o(data), .valid_o(valid), .ready_i(ready));

  always #5 clk = ~clk;
  assign gnt = req & ~stall;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave: one-cycle read latency, data equals the granted address.
  logic        s_g;
  logic [31:0] s_a;
  always @(posedge clk) begin
    s_g = req & gnt;
    s_a = add;
    #1;
    rv    = s_g | inj;
    rdata = inj ? 32'hDEADBEEF : s_a;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model state
  logic [31:0] exp_addr[$], exp_data[$], glog[$], plog[$];
  int          gcyc[$];
  int          inflight = 0, done_cd = 0, last_pop_cyc = 0, dut_done_cyc = 0, start_cyc = 0;
  bit          m_busy = 0, prev_pend = 0, mon_on = 0, exp_done;
  logic [31:0] prev_add = '0, a_w;

  task automatic flush_model();
    exp_addr.delete(); exp_data.delete();
    inflight = 0; done_cd = 0; m_busy = 0; prev_pend = 0;
  endtask

  // Compare process: every cycle, DUT outputs against the model.
  always @(negedge clk) begin
    if (mon_on) begin
      exp_done = (done_cd == 1);
      if (exp_done) m_busy = 0;
      chk("done_o", 32'(done), 32'(exp_done));
      chk("busy_o", 32'(busy), 32'(m_busy));
      chk("wen_o", 32'(wen), 32'd1);
      chk("be_o", 32'(be), 32'hF);
      chk("wdata_o", wdata, 32'd0);
      if (!m_busy) chk("req_idle", 32'(req), 32'd0);
      if (prev_pend) begin
        chk("req_hold", 32'(req), 32'd1);
        chk("add_hold", add, prev_add);
      end
      if (req && gnt) begin
        glog.push_back(add); gcyc.push_back(cyc);
        if (exp_addr.size() == 0) begin
          total++; bad++;
          $display("FAIL grant_addr: got grant at %h want no request", add);
        end else chk("grant_addr", add, exp_addr.pop_front());
        inflight++;
      end
      if (valid && ready) begin
        plog.push_back(data); last_pop_cyc = cyc;
        if (exp_data.size() == 0) begin
          total++; bad++;
          $display("FAIL data_o: got word %h want no word", data);
        end else begin
          chk("data_o", data, exp_data.pop_front());
          if (exp_data.size() == 0) done_cd = 2;
        end
        inflight--;
      end
      chk("credit", 32'(inflight <= DEPTH), 32'd1);
      if (start && !m_busy && !exp_done) begin
        a_w = base & ~32'd3;
        for (int i = 0; i < int'(len); i++) begin
          exp_addr.push_back(a_w); exp_data.push_back(a_w);
          a_w = a_w + 32'd4;
        end
        m_busy = 1;
        if (len == 0) done_cd = 3;
      end
      prev_pend = req && !gnt;
      prev_add  = add;
      if (done_cd > 0) done_cd--;
    end
  end

  task automatic do_start(input logic [31:0] b, input logic [15:0] l);
    @(posedge clk); #1;
    start_cyc = cyc; base = b; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1; dut_done_cyc = cyc; end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL wait_done: got no done_o within %0d cycles want a pulse", budget);
    end
  endtask

  task automatic clr_logs();
    glog.delete(); plog.delete(); gcyc.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   32'(req),   32'd0);
    chk({tag, "_add"},   add,        32'd0);
    chk({tag, "_busy"},  32'(busy),  32'd0);
    chk({tag, "_done"},  32'(done),  32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_data"},  data,       32'd0);
  endtask

  initial begin
    #2 chk_reset_vals("rst");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 mon_on = 1;

    // 1: zero-wait, back-to-back
    clr_logs();
    do_start(32'h1A000000, 16'd4);
    wait_done(40);
    chk("t1_ngrant", glog.size(), 32'd4);
    chk("t1_g0", glog[0], 32'h1A000000);
    chk("t1_g3", glog[3], 32'h1A00000C);
    chk("t1_b2b", gcyc[3] - gcyc[0], 32'd3);
    chk("t1_p3", plog[3], 32'h1A00000C);
    chk("t1_done_lat", dut_done_cyc - last_pop_cyc, 32'd1);

    // 2: stream stalled, credit limits grants to the buffer depth
    clr_logs();
    ready = 1'b0;
    do_start(32'h1A001000, 16'd8);
    repeat (12) @(negedge clk);
    chk("t2_ngrant_stalled", glog.size(), 32'd4);
    chk("t2_req_low", 32'(req), 32'd0);
    @(posedge clk); #1 ready = 1'b1;
    wait_done(80);
    chk("t2_ngrant", glog.size(), 32'd8);
    chk("t2_npop", plog.size(), 32'd8);
    chk("t2_p7", plog[7], 32'h1A00101C);

    // 3: grant withheld 3 cycles on the 2nd request
    clr_logs();
    do_start(32'h1A002000, 16'd3);
    @(posedge clk); #1 stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t3_req", 32'(req), 32'd1);
      chk("t3_add", add, 32'h1A002004);
    end
    @(posedge clk); #1 stall = 1'b0;
    wait_done(40);
    chk("t3_g0", glog[0], 32'h1A002000);
    chk("t3_npop", plog.size(), 32'd3);
    chk("t3_p1", plog[1], 32'h1A002004);

    // 4: zero length
    clr_logs();
    do_start(32'h1C000000, 16'd0);
    wait_done(10);
    chk("t4_done_lat", dut_done_cyc - start_cyc, 32'd2);
    chk("t4_ngrant", glog.size(), 32'd0);

    // 5: second start mid-transfer is ignored
    clr_logs();
    do_start(32'h1A003000, 16'd5);
    @(posedge clk); #1;
    base = 32'h1B000000; len = 16'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(60);
    chk("t5_ngrant", glog.size(), 32'd5);
    chk("t5_p4", plog[4], 32'h1A003010);

    // 6: address wraps at the top of the space
    clr_logs();
    do_start(32'hFFFFFFF8, 16'd3);
    wait_done(40);
    chk("t6_g0", glog[0], 32'hFFFFFFF8);
    chk("t6_g1", glog[1], 32'hFFFFFFFC);
    chk("t6_g2", glog[2], 32'h00000000);

    // 7: reset mid-transfer, stray response, then a fresh transfer
    clr_logs();
    do_start(32'h1A004000, 16'd6);
    @(posedge clk); @(posedge clk); #2;
    chk("t7_ngrant", glog.size(), 32'd2);
    mon_on = 0;
    rst_n = 1'b0;
    #1 chk_reset_vals("t7_rst");
    @(negedge clk);
    rst_n = 1'b1;
    flush_model();
    #1 mon_on = 1;
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    chk("t7_valid_a", 32'(valid), 32'd0);
    @(negedge clk);
    chk("t7_valid_b", 32'(valid), 32'd0);
    chk("t7_busy", 32'(busy), 32'd0);
    clr_logs();
    do_start(32'h1A005000, 16'd2);
    wait_done(40);
    chk("t7_npop", plog.size(), 32'd2);
    chk("t7_p1", plog[1], 32'h1A005004);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/tcdm_burst_reader.md
Name: tcdm_burst_reader

Overview:
TCDM initiator that fetches a block of consecutive 32-bit words from any TCDM slave (boot ROM, L2, peripheral memories) and presents them as a valid/ready stream. It is the requesting side of the single-cycle-latency TCDM handshake that SoC slaves implement. It is used by boot and copy engines that need to read ROM or L2 contents without a core.

Parameters:
ADDR_WIDTH, 32, TCDM byte address width.
DATA_WIDTH, 32, TCDM data width; the stream carries the same width.
LEN_WIDTH, 16, width of the word-count input.
FIFO_DEPTH, 4, response buffer depth in words; must be a power of 2 and at least 2.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  one-cycle pulse; sampled only in IDLE
base_addr_i  in  ADDR_WIDTH  start byte address; bits [1:0] are ignored
len_i  in  LEN_WIDTH  number of words to read
busy_o  out  1  high from an accepted start until done_o
done_o  out  1  one-cycle pulse when the last word leaves the stream
tcdm_req_o  out  1  TCDM request
tcdm_add_o  out  ADDR_WIDTH  TCDM byte address, word aligned
tcdm_wen_o  out  1  constant 1 (read)
tcdm_be_o  out  DATA_WIDTH/8  constant all-ones
tcdm_wdata_o  out  DATA_WIDTH  constant 0
tcdm_gnt_i  in  1  TCDM grant
tcdm_r_valid_i  in  1  response valid, in order
tcdm_r_rdata_i  in  DATA_WIDTH  response data
data_o  out  DATA_WIDTH  stream data
valid_o  out  1  stream valid
ready_i  in  1  stream ready

Behaviour:
- Reset values: tcdm_req_o=0, tcdm_add_o=0, busy_o=0, done_o=0, valid_o=0, data_o=0. FIFO is empty; all counters are 0; state is IDLE.
- FSM states are IDLE, REQ, DRAIN, DONE.
- IDLE: on start_i, latch addr={base_addr_i[ADDR_WIDTH-1:2],2'b00}, req_left=len_i and out_left=len_i; set busy_o.
  - If len_i==0, go to DONE.
  - Otherwise go to REQ.
  - start_i in any other state is ignored.
- REQ:
  - Drive tcdm_req_o=1 whenever credit is available. Credit means outstanding + fifo_count < FIFO_DEPTH, where outstanding is the number of granted requests whose r_valid has not yet arrived.
  - On each cycle with req&gnt: addr+=4 (wraps modulo 2^ADDR_WIDTH), req_left-=1, outstanding+=1.
  - When the final request is granted, go to DRAIN.
- TCDM rule: once tcdm_req_o is asserted, it and tcdm_add_o stay stable until gnt. Credit loss may not retract a pending request. The credit check is made only when raising req from low.
- Back-to-back requests are allowed: with gnt=req, one grant per cycle.
- Response path:
  - Each r_valid pushes r_rdata into the FIFO and decrements outstanding.
  - The credit rule guarantees the FIFO never overflows; r_valid arriving with the FIFO full is a protocol violation and is flagged by an assertion.
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - The response may arrive in the cycle after the grant at the earliest (1-cycle latency); later arrival is tolerated.
- Stream: valid_o = FIFO not empty; data_o = FIFO head. A pop happens on valid_o&ready_i and decrements out_left.
- DRAIN: wait until out_left==0, then go to DONE.
- DONE: pulse done_o for one cycle, clear busy_o, return to IDLE. A start_i in the cycle after done_o is accepted.
- r_valid while outstanding==0 is ignored and flagged by an assertion.
- Async reset mid-transfer returns to reset values immediately. Responses still in flight from the slave after reset are not pushed, because outstanding==0 causes them to be dropped.
- Counters are LEN_WIDTH bits. outstanding and fifo_count are clog2(FIFO_DEPTH)+1 bits.

Test Plan:
- Zero-wait slave (gnt=req, r_valid one cycle later, rdata=addr), ready_i=1, base=0x1A000000, len=4:
  - Addresses 0x1A000000, 04, 08, 0C are granted on 4 consecutive cycles.
  - data_o carries the same values in order.
  - done_o pulses once, one cycle after the 4th pop; busy_o is then 0.
- Same slave, ready_i=0, len=8, FIFO_DEPTH=4:
  - Exactly 4 grants occur, then req stays low.
  - Raising ready_i resumes requests.
  - All 8 words arrive in order with none lost.
- gnt held low 3 cycles on the 2nd request:
  - tcdm_req_o stays 1 and tcdm_add_o is held at base+4 for those 3 cycles.
  - The transfer completes with correct data.
- len=0 at base=0x1C000000: no tcdm_req_o ever; busy_o is high 1 cycle; done_o pulses 2 cycles after start_i.
- start_i pulsed again mid-transfer with different base/len: it is ignored, and the original transfer completes unchanged.
- base=0xFFFFFFF8, len=3: addresses are 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Reset mid-transfer:
  - Assert rst_ni low after 2 grants of len=6; all outputs go to reset values immediately.
  - After release, the late r_valid is ignored.
  - A new start with len=2 completes normally.
